golden_nonce_reporter: RTL and testbench

//  Downstream of the SHA-256 miner control unit, in the hash_clk domain. Captures golden-nonce

---
 rtl/miner_pkg.sv | 29 ++
 rtl/nonce_fifo.sv | 58 +++++
 rtl/golden_nonce_reporter.sv | 140 ++++++++++++++
 tb/tb_golden_nonce_reporter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the miner reporting path.
//   PAYLOAD_W      width of a framed payload handed to the packetiser
//   ENTRY_W        width of a queued entry {tag[15:0], nonce[31:0]}
//   MAGIC_DEFAULT  default payload header byte
//   gnr_state_e    reporter FSM state encoding
//   frame_payload  builds {magic, seq, tag, nonce}
package miner_pkg;

  localparam int unsigned PAYLOAD_W     = 64;
  localparam int unsigned ENTRY_W       = 48;
  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STROBE  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } gnr_state_e;

  function automatic logic [PAYLOAD_W-1:0] frame_payload(
    input logic [7:0]         magic,
    input logic [7:0]         seq,
    input logic [ENTRY_W-1:0] entry
  );
    return {magic, seq, entry};
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Small first-word-fall-through FIFO holding {tag, nonce} entries.
//   clk, reset  clock and asynchronous active-high reset
//   push, din   write request and data; accepted when not full or when popping
//   pop         read request; dout is the head, valid in the cycle it is popped
//   count       entries held (0..DEPTH)
//   full/empty  occupancy flags
module nonce_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);
  // When full, a same-cycle pop frees the slot being written; the head is
  // read combinationally before the write lands.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Queues golden nonces and hands each one, framed as a 64-bit payload, to the
// MIPI TX packetiser with a write_enable strobe and a busy-flag handshake.
//   hash_clk, reset  clock and asynchronous active-high reset
//   nonce_valid      1-cycle pulse qualifying golden_nonce / job_tag
//   golden_nonce     winning nonce
//   job_tag          low 16 bits of the current midstate
//   tx_busy          packetiser busy (foreign domain, synchronised here)
//   pix_gen_data     payload {MAGIC, seq, tag, nonce}
//   write_enable     payload-present strobe, WE_CYCLES long
//   fifo_count       entries queued
//   drop_cnt         saturating count of nonces lost to a full queue
//   tmo_err          1-cycle pulse when tx_busy never answered a payload
module golden_nonce_reporter
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WE_CYCLES = 32,
  parameter int unsigned BUSY_TMO  = 1024,
  parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic                 nonce_valid,
  input  logic [31:0]          golden_nonce,
  input  logic [15:0]          job_tag,
  input  logic                 tx_busy,
  output logic [PAYLOAD_W-1:0] pix_gen_data,
  output logic                 write_enable,
  output logic [4:0]           fifo_count,
  output logic [15:0]          drop_cnt,
  output logic                 tmo_err
);

  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [7:0]       WE_LAST  = 8'(WE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  gnr_state_e         state;
  logic               busy_m;
  logic               busy_s;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] pend;
  logic [7:0]         seq;
  logic [7:0]         we_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= tx_busy;
      busy_s <= busy_m;
    end
  end

  assign pop = (state == IDLE) && !fifo_empty && !busy_s;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (hash_clk),
    .reset (reset),
    .push  (nonce_valid),
    .din   ({job_tag, golden_nonce}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (nonce_valid && fifo_full && !pop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pend         <= '0;
      pix_gen_data <= '0;
      write_enable <= 1'b0;
      tmo_err      <= 1'b0;
      seq          <= '0;
      we_cnt       <= '0;
      tmo_cnt      <= '0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          // The head is captured as it is popped so the FIFO slot is free
          // while the payload is framed.
          if (pop) begin
            pend  <= fifo_dout;
            state <= LOAD;
          end
        end
        LOAD: begin
          pix_gen_data <= frame_payload(MAGIC, seq, pend);
          seq          <= seq + 8'd1;
          write_enable <= 1'b1;
          we_cnt       <= WE_LAST;
          state        <= STROBE;
        end
        STROBE: begin
          if (we_cnt == '0) begin
            write_enable <= 1'b0;
            tmo_cnt      <= '0;
            state        <= WAIT_HI;
          end else begin
            we_cnt <= we_cnt - 8'd1;
          end
        end
        WAIT_HI: begin
          if (busy_s) begin
            state <= WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WAIT_LO: begin
          if (!busy_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
module tb_golden_nonce_reporter;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned WE_CYCLES = 12;
  localparam int unsigned BUSY_TMO  = 64;
  localparam logic [7:0]  MAGIC     = 8'hA5;

  logic        hash_clk;
  logic        reset;
  logic        nonce_valid;
  logic [31:0] golden_nonce;
  logic [15:0] job_tag;
  logic        tx_busy;
  logic [63:0] pix_gen_data;
  logic        write_enable;
  logic [4:0]  fifo_count;
  logic [15:0] drop_cnt;
  logic        tmo_err;

  int checks = 0;
  int failures = 0;
  int tmo_pulses = 0;

  // packetiser model: busy rises 10 cycles after write_enable rises, stays
  // high at least 6 cycles and falls once write_enable is low
  bit   auto_busy = 0;
  logic busy_manual = 0;
  logic busy_model = 0;
  assign tx_busy = auto_busy ? busy_model : busy_manual;

  golden_nonce_reporter #(
    .DEPTH     (DEPTH),
    .WE_CYCLES (WE_CYCLES),
    .BUSY_TMO  (BUSY_TMO),
    .MAGIC     (MAGIC)
  ) dut (
    .hash_clk     (hash_clk),
    .reset        (reset),
    .nonce_valid  (nonce_valid),
    .golden_nonce (golden_nonce),
    .job_tag      (job_tag),
    .tx_busy      (tx_busy),
    .pix_gen_data (pix_gen_data),
    .write_enable (write_enable),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt),
    .tmo_err      (tmo_err)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  initial begin
    int   rise_cnt;
    int   hold_cnt;
    logic we_prev;
    rise_cnt = 0;
    hold_cnt = 0;
    we_prev  = 1'b0;
    forever begin
      @(negedge hash_clk);
      if (!auto_busy) begin
        busy_model = 1'b0;
        rise_cnt   = 0;
      end else begin
        if (write_enable && !we_prev) begin
          rise_cnt = 10;
        end else if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) begin
            busy_model = 1'b1;
            hold_cnt   = 6;
          end
        end
        if (busy_model && rise_cnt == 0) begin
          if (hold_cnt > 0) hold_cnt--;
          else if (!write_enable) busy_model = 1'b0;
        end
      end
      we_prev = write_enable;
    end
  end

  initial begin
    forever begin
      @(negedge hash_clk);
      if (tmo_err === 1'b1) tmo_pulses++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    nonce_valid  = 1'b0;
    auto_busy    = 0;
    busy_manual  = 1'b0;
    golden_nonce = '0;
    job_tag      = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_one(input logic [31:0] n, input logic [15:0] t);
    golden_nonce = n;
    job_tag      = t;
    nonce_valid  = 1'b1;
    tick();
    nonce_valid  = 1'b0;
  endtask

  task automatic wait_we(input logic level, output bit ok);
    int n;
    n = 0;
    while (write_enable !== level && n < 400) begin
      tick();
      n++;
    end
    ok = (write_enable === level);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nonce_valid = 1'b0;
    golden_nonce = '0;
    job_tag = '0;
    repeat (3) tick();
    checks++; if (pix_gen_data !== 64'd0) begin failures++; $display("FAIL reset_pix got=%h exp=%h", pix_gen_data, 64'd0); end
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", write_enable); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b exp=0", tmo_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int  n;
    int  base;
    bit  ok;
    do_reset();
    auto_busy = 1;
    base = tmo_pulses;
    push_one(32'hDEADBEEF, 16'h1234);
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL single_lat0 got=%b exp=0", write_enable); end
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL single_lat1 got=%b exp=0", write_enable); end
    tick();
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL single_lat2 got=%b exp=1", write_enable); end
    checks++; if (pix_gen_data !== 64'hA5001234DEADBEEF) begin failures++; $display("FAIL single_pix got=%h exp=%h", pix_gen_data, 64'hA5001234DEADBEEF); end
    n = 0;
    while (write_enable === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n != WE_CYCLES) begin failures++; $display("FAIL single_we_len got=%0d exp=%0d", n, WE_CYCLES); end
    checks++; if (pix_gen_data !== 64'hA5001234DEADBEEF) begin failures++; $display("FAIL single_pix_hold got=%h exp=%h", pix_gen_data, 64'hA5001234DEADBEEF); end
    repeat (20) tick();
    checks++; if (tmo_pulses - base != 0) begin failures++; $display("FAIL single_no_tmo got=%0d exp=0", tmo_pulses - base); end
    // back in IDLE: a new nonce sees the same 2-cycle latency
    push_one(32'h0BADF00D, 16'h5678);
    tick();
    tick();
    checks++; if (write_enable !== 1'b1 || pix_gen_data !== 64'hA50156780BADF00D) begin failures++; $display("FAIL single_idle_again got we=%b pix=%h exp we=1 pix=%h", write_enable, pix_gen_data, 64'hA50156780BADF00D); end
    wait_we(1'b0, ok);
    repeat (20) tick();
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [63:0] exp;
    do_reset();
    busy_manual = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      golden_nonce = 32'hA0000000 + 32'(i);
      job_tag      = 16'h2000 + 16'(i);
      nonce_valid  = 1'b1;
      tick();
    end
    nonce_valid = 1'b0;
    checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", fifo_count); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL b2b_drop got=%0d exp=1", drop_cnt); end
    busy_manual = 1'b0;
    auto_busy   = 1;
    for (int i = 0; i < 4; i++) begin
      exp = {MAGIC, 8'(i), 16'h2000 + 16'(i), 32'hA0000000 + 32'(i)};
      wait_we(1'b1, ok);
      checks++; if (!ok || pix_gen_data !== exp) begin failures++; $display("FAIL b2b_payload%0d got=%h exp=%h", i, pix_gen_data, exp); end
      wait_we(1'b0, ok);
    end
    repeat (30) tick();
    checks++; if (fifo_count !== 5'd0 || write_enable !== 1'b0) begin failures++; $display("FAIL b2b_drained got count=%0d we=%b exp count=0 we=0", fifo_count, write_enable); end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    int base;
    do_reset();
    base = tmo_pulses;
    push_one(32'hCAFEF00D, 16'h0001);
    wait_we(1'b1, ok);
    checks++; if (!ok || pix_gen_data !== 64'hA5000001CAFEF00D) begin failures++; $display("FAIL tmo_first got=%h exp=%h", pix_gen_data, 64'hA5000001CAFEF00D); end
    wait_we(1'b0, ok);
    k = 0;
    while (tmo_err !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    checks++; if (k != BUSY_TMO) begin failures++; $display("FAIL tmo_delay got=%0d exp=%0d", k, BUSY_TMO); end
    tick();
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse_len got=%b exp=0", tmo_err); end
    checks++; if (tmo_pulses - base != 1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", tmo_pulses - base); end
    auto_busy = 1;
    push_one(32'h12345678, 16'hBEEF);
    wait_we(1'b1, ok);
    checks++; if (!ok || pix_gen_data !== 64'hA501BEEF12345678) begin failures++; $display("FAIL tmo_next_seq got=%h exp=%h", pix_gen_data, 64'hA501BEEF12345678); end
    wait_we(1'b0, ok);
  endtask

  task automatic test_push_pop_full();
    bit          ok;
    logic [63:0] exp;
    do_reset();
    busy_manual = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      golden_nonce = 32'hE0000000 + 32'(i);
      job_tag      = 16'h3000 + 16'(i);
      nonce_valid  = 1'b1;
      tick();
    end
    nonce_valid = 1'b0;
    checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL ppf_fill got=%0d exp=4", fifo_count); end
    // busy_s falls two edges after tx_busy; the pop happens on the third
    busy_manual = 1'b0;
    tick();
    tick();
    golden_nonce = 32'hE0000004;
    job_tag      = 16'h3004;
    nonce_valid  = 1'b1;
    tick();
    nonce_valid  = 1'b0;
    checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL ppf_count got=%0d exp=4", fifo_count); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL ppf_drop got=%0d exp=0", drop_cnt); end
    auto_busy = 1;
    for (int i = 0; i < 5; i++) begin
      exp = {MAGIC, 8'(i), 16'h3000 + 16'(i), 32'hE0000000 + 32'(i)};
      wait_we(1'b1, ok);
      checks++; if (!ok || pix_gen_data !== exp) begin failures++; $display("FAIL ppf_payload%0d got=%h exp=%h", i, pix_gen_data, exp); end
      wait_we(1'b0, ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      golden_nonce = 32'h50000000 + 32'(i);
      job_tag      = 16'h5000 + 16'(i);
      nonce_valid  = 1'b1;
      tick();
    end
    nonce_valid = 1'b0;
    checks++; if (fifo_count !== 5'd2 || write_enable !== 1'b1) begin failures++; $display("FAIL rst_mid_setup got count=%0d we=%b exp count=2 we=1", fifo_count, write_enable); end
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", write_enable); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", fifo_count); end
    tick();
    reset = 1'b0;
    tick();
    auto_busy = 1;
    push_one(32'h00C0FFEE, 16'h4242);
    wait_we(1'b1, ok);
    checks++; if (!ok || pix_gen_data !== 64'hA500424200C0FFEE) begin failures++; $display("FAIL rst_mid_seq got=%h exp=%h", pix_gen_data, 64'hA500424200C0FFEE); end
    wait_we(1'b0, ok);
  endtask

  task automatic test_seq_wrap();
    bit          ok;
    logic [63:0] exp;
    do_reset();
    auto_busy = 1;
    for (int i = 0; i < 257; i++) begin
      exp = {MAGIC, 8'(i), 16'(i), 32'h10000000 + 32'(i)};
      push_one(32'h10000000 + 32'(i), 16'(i));
      wait_we(1'b1, ok);
      checks++; if (!ok || pix_gen_data !== exp) begin failures++; $display("FAIL wrap_payload%0d got=%h exp=%h", i, pix_gen_data, exp); end
      wait_we(1'b0, ok);
    end
    repeat (30) tick();
    checks++; if (fifo_count !== 5'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL wrap_end got count=%0d drop=%0d exp 0 0", fifo_count, drop_cnt); end
  endtask

  task automatic test_drop_saturation();
    auto_busy   = 0;
    busy_manual = 1'b1;
    repeat (3) tick();
    golden_nonce = 32'h77777777;
    job_tag      = 16'h7777;
    nonce_valid  = 1'b1;
    repeat (4 + 65533) tick();
    checks++; if (drop_cnt !== 16'hFFFD) begin failures++; $display("FAIL sat_near got=%h exp=%h", drop_cnt, 16'hFFFD); end
    checks++; if (fifo_count !== 5'd4) begin failures++; $display("FAIL sat_count got=%0d exp=4", fifo_count); end
    repeat (10) tick();
    nonce_valid = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=%h", drop_cnt, 16'hFFFF); end
    tick();
    checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold2 got=%h exp=%h", drop_cnt, 16'hFFFF); end
    do_reset();
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL sat_reset got=%h exp=0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_push_pop_full();
    test_reset_mid();
    test_seq_wrap();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
